// File: rtl/carrier_mask_gen_pkg.sv
// Shared types and constants for the triangular carrier / mask-event generator.
package carrier_mask_gen_pkg;

    localparam int CARR_WIDTH_DEF = 16;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } _carr_onoff;

    typedef enum logic [1:0] {
        NO_MASK     = 2'd0,
        MIN_MASK    = 2'd1,
        MAX_MASK    = 2'd2,
        MINMAX_MASK = 2'd3
    } _mask_mode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } _carr_state;

    // Whether the given mask mode wants a pulse at this extreme (at_max=1: peak, 0: minimum).
    function automatic logic mask_hit(input _mask_mode mode, input logic at_max);
        logic hit;
        case (mode)
            MINMAX_MASK: hit = 1'b1;
            MAX_MASK:    hit = at_max;
            MIN_MASK:    hit = ~at_max;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/carrier_period_shadow.sv
// Period shadow register: period_in is copied to period_active on start, at carrier
// minimum, and every clock while the carrier is stalled on a zero period.
module carrier_period_shadow
    import carrier_mask_gen_pkg::*;
#(
    parameter int CARR_WIDTH = CARR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  _carr_onoff            carr_onoff,
    input  _carr_state            state,
    input  logic [CARR_WIDTH-1:0] carrier,
    input  logic [CARR_WIDTH-1:0] period_in,
    output logic [CARR_WIDTH-1:0] period_active,
    output logic                  min_reach
);

    localparam logic [CARR_WIDTH-1:0] CARR_ONE = {{(CARR_WIDTH-1){1'b0}}, 1'b1};

    logic [CARR_WIDTH-1:0] period_q;
    logic [CARR_WIDTH-1:0] period_d;
    logic                  load_s;

    // Load strobe and minimum-reached strobe; a DOWN carrier at 0 is treated as a minimum too.
    always_comb begin
        min_reach = 1'b0;
        load_s    = 1'b0;
        if (carr_onoff == ON) begin
            min_reach = (state == DOWN) && (carrier == CARR_ONE);
            load_s    = (state == IDLE)
                     || ((state == UP) && (period_q == '0))
                     || ((state == DOWN) && (carrier <= CARR_ONE));
        end else begin
            min_reach = 1'b0;
            load_s    = 1'b0;
        end
    end

    // Next shadow value.
    always_comb begin
        if (load_s) begin
            period_d = period_in;
        end else begin
            period_d = period_q;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign period_active = period_q;

endmodule

// File: rtl/carrier_mask_gen.sv
// Up-down PWM carrier with mask-event pulses at the selected extremes.
// Optional feature macro CARR_PHASE_EN adds phase_in for a non-zero start point.
module carrier_mask_gen
    import carrier_mask_gen_pkg::*;
#(
    parameter int CARR_WIDTH = CARR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  _carr_onoff            carr_onoff,
    input  _mask_mode             maskmode,
    input  logic [CARR_WIDTH-1:0] period_in,
`ifdef CARR_PHASE_EN
    input  logic [CARR_WIDTH-1:0] phase_in,
`endif
    output logic [CARR_WIDTH-1:0] carrier,
    output logic                  carr_dir,
    output logic [CARR_WIDTH-1:0] period_active,
    output logic                  maskevent
);

    localparam logic [CARR_WIDTH-1:0] CARR_ONE = {{(CARR_WIDTH-1){1'b0}}, 1'b1};

    _carr_state            state_q, state_d;
    logic [CARR_WIDTH-1:0] carrier_q, carrier_d;
    logic                  dir_q, dir_d;
    logic                  evt_q, evt_d;
    logic [CARR_WIDTH-1:0] period_s;
    logic                  min_reach_s;

    carrier_period_shadow #(
        .CARR_WIDTH (CARR_WIDTH)
    ) u_shadow (
        .clk           (clk),
        .resetn        (resetn),
        .carr_onoff    (carr_onoff),
        .state         (state_q),
        .carrier       (carrier_q),
        .period_in     (period_in),
        .period_active (period_s),
        .min_reach     (min_reach_s)
    );

    // Next-state logic; carr_dir reports the direction of the step just taken.
    always_comb begin
        state_d   = state_q;
        carrier_d = carrier_q;
        dir_d     = dir_q;
        evt_d     = 1'b0;
        if (carr_onoff == OFF) begin
            state_d   = IDLE;
            carrier_d = '0;
            dir_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    dir_d = 1'b1;
`ifdef CARR_PHASE_EN
                    if (phase_in < period_in) begin
                        carrier_d = phase_in;
                        state_d   = UP;
                    end else begin
                        carrier_d = period_in;
                        state_d   = DOWN;
                    end
`else
                    carrier_d = '0;
                    state_d   = UP;
`endif
                end
                UP: begin
                    if (carrier_q < period_s) begin
                        carrier_d = carrier_q + CARR_ONE;
                        dir_d     = 1'b1;
                        if ((carrier_q + CARR_ONE) == period_s) begin
                            evt_d   = mask_hit(maskmode, 1'b1);
                            state_d = DOWN;
                        end else begin
                            state_d = UP;
                        end
                    end else if (period_s != '0) begin
                        state_d = DOWN;
                    end else begin
                        state_d = UP;
                    end
                end
                DOWN: begin
                    // A zero carrier here only arises from a phased start on a zero period.
                    if (carrier_q == '0) begin
                        state_d = UP;
                    end else begin
                        carrier_d = carrier_q - CARR_ONE;
                        dir_d     = 1'b0;
                        if (min_reach_s) begin
                            evt_d   = mask_hit(maskmode, 1'b0);
                            state_d = UP;
                        end else begin
                            state_d = DOWN;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    carrier_d = '0;
                    dir_d     = 1'b1;
                end
            endcase
        end
    end

    // Carrier state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            carrier_q <= '0;
            dir_q     <= 1'b1;
            evt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            dir_q     <= dir_d;
            evt_q     <= evt_d;
        end
    end

    assign carrier       = carrier_q;
    assign carr_dir      = dir_q;
    assign period_active = period_s;
    assign maskevent     = evt_q;

endmodule

// File: tb/tb_carrier_mask_gen.sv
// Randomized self-checking bench for carrier_mask_gen against a queue-based triangle model.
module tb_carrier_mask_gen;
    import carrier_mask_gen_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         resetn;
    _carr_onoff   onoff;
    _mask_mode    mode;
    logic [W-1:0] period_in;
    logic [W-1:0] carrier;
    logic         carr_dir;
    logic [W-1:0] period_active;
    logic         maskevent;
`ifdef CARR_PHASE_EN
    logic [W-1:0] phase_in;
    assign phase_in = '0;
`endif

    int total = 0;
    int bad   = 0;

    carrier_mask_gen #(.CARR_WIDTH(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .carr_onoff    (onoff),
        .maskmode      (mode),
        .period_in     (period_in),
`ifdef CARR_PHASE_EN
        .phase_in      (phase_in),
`endif
        .carrier       (carrier),
        .carr_dir      (carr_dir),
        .period_active (period_active),
        .maskevent     (maskevent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each triangle is expanded into a queue of upcoming carrier samples.
    typedef struct {
        int val;
        bit up;
        bit is_max;
        bit is_min;
    } samp_t;

    samp_t q[$];
    bit    m_run;
    int    m_car;
    int    m_pact;
    bit    m_dir;
    bit    m_evt;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run  = 1'b0;
        m_car  = 0;
        m_pact = 0;
        m_dir  = 1'b1;
        m_evt  = 1'b0;
    endtask

    task automatic model_edge();
        samp_t s;
        m_evt = 1'b0;
        if (onoff == OFF) begin
            q.delete();
            m_run = 1'b0;
            m_car = 0;
            m_dir = 1'b1;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_pact = int'(period_in);
            m_car  = 0;
            m_dir  = 1'b1;
        end else begin
            if (q.size() == 0 && m_pact != 0) begin
                for (int k = 1; k <= m_pact; k++)
                    q.push_back('{val: k, up: 1'b1, is_max: (k == m_pact), is_min: 1'b0});
                for (int k = m_pact - 1; k >= 0; k--)
                    q.push_back('{val: k, up: 1'b0, is_max: 1'b0, is_min: (k == 0)});
            end
            if (q.size() == 0) begin
                m_pact = int'(period_in);
            end else begin
                s     = q.pop_front();
                m_car = s.val;
                m_dir = s.up;
                m_evt = (s.is_max && (mode == MAX_MASK || mode == MINMAX_MASK))
                     || (s.is_min && (mode == MIN_MASK || mode == MINMAX_MASK));
                if (s.is_min) m_pact = int'(period_in);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_eq("carrier", 32'(carrier), 32'(m_car));
        chk_eq("carr_dir", 32'(carr_dir), 32'(m_dir));
        chk_eq("period_active", 32'(period_active), 32'(m_pact));
        chk_eq("maskevent", 32'(maskevent), 32'(m_evt));
    endtask

    task automatic run_until(input int val, input bit up, input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            if (m_car == val && m_dir == up) hit = 1'b1;
        end
        chk_eq("wait_timeout", 32'(hit), 32'd1);
    endtask

    int exp_car[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    bit exp_evt[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    int pulses;

    initial begin
        resetn    = 1'b0;
        onoff     = OFF;
        mode      = NO_MASK;
        period_in = '0;
        model_reset();
        #12;
        chk_eq("rst_carrier", 32'(carrier), 32'd0);
        chk_eq("rst_dir", 32'(carr_dir), 32'd1);
        chk_eq("rst_period", 32'(period_active), 32'd0);
        chk_eq("rst_evt", 32'(maskevent), 32'd0);
        resetn = 1'b1;

        // First triangle, period 4, both extremes
        period_in = 16'd4;
        mode      = MINMAX_MASK;
        onoff     = ON;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_eq("tri4_carrier", 32'(carrier), 32'(exp_car[i]));
            chk_eq("tri4_evt", 32'(maskevent), 32'(exp_evt[i]));
        end

        // Peaks only over three triangles
        mode   = MAX_MASK;
        pulses = 0;
        run_until(0, 1'b0, 20);
        for (int i = 0; i < 24; i++) begin
            step();
            if (maskevent) begin
                pulses++;
                chk_eq("max_peak", 32'(carrier), 32'd4);
            end
        end
        chk_eq("max_pulses", 32'(pulses), 32'd3);

        // Period shrinks mid-ramp: current triangle still peaks at 4
        run_until(3, 1'b1, 20);
        period_in = 16'd2;
        step();
        chk_eq("peak_kept", 32'(carrier), 32'd4);
        for (int i = 0; i < 10; i++) step();

        // Enable dropped while descending
        period_in = 16'd4;
        run_until(3, 1'b0, 30);
        onoff = OFF;
        step();
        chk_eq("off_carrier", 32'(carrier), 32'd0);
        step();
        onoff = ON;
        for (int i = 0; i < 10; i++) step();

        // Zero period stall, then period 1
        period_in = 16'd0;
        mode      = MINMAX_MASK;
        run_until(0, 1'b0, 20);
        for (int i = 0; i < 8; i++) step();
        period_in = 16'd1;
        for (int i = 0; i < 8; i++) step();

        // Asynchronous reset between clock edges
        period_in = 16'd4;
        for (int i = 0; i < 5; i++) step();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk_eq("arst_carrier", 32'(carrier), 32'd0);
        chk_eq("arst_dir", 32'(carr_dir), 32'd1);
        chk_eq("arst_period", 32'(period_active), 32'd0);
        chk_eq("arst_evt", 32'(maskevent), 32'd0);
        #2;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) period_in = W'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) mode = _mask_mode'(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 39) == 0) onoff = (onoff == ON) ? OFF : ON;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
